// File: rtl/flop_stim_pkg.sv
// Shared types, LFSR constants and arithmetic helpers for the negedge-flop stimulus launcher.
package flop_stim_pkg;

    typedef enum logic [1:0] {
        ALL0 = 2'd0,
        ALL1 = 2'd1,
        ALT  = 2'd2,
        LFSR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned     LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int unsigned     SAT_W     = 32;
    localparam int unsigned     POP_W     = 5;

    // Galois right-shift step for x^16+x^14+x^13+x^11+1
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b,
                                                  input logic [SAT_W-1:0] max);
        logic [SAT_W:0] sum;
        sum     = {1'b0, a} + {1'b0, b};
        sat_add = (sum > {1'b0, max}) ? max : sum[SAT_W-1:0];
    endfunction

    function automatic logic [POP_W-1:0] popcount16(input logic [15:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        popcount16 = cnt;
    endfunction

endpackage

// File: rtl/flop_stim_lfsr.sv
// 16-bit Galois LFSR; load and adv together produce one step from the seed.
module flop_stim_lfsr
    import flop_stim_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= seed;
        end else if (load && adv) begin
            state <= lfsr_step(seed);
        end else if (load) begin
            state <= seed;
        end else if (adv) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/flop_stim_launcher.sv
// Launches D patterns on rising CLK into negedge-capture flops, checks Q/QN one cycle later
// and counts D toggles and mismatching cycles.
module flop_stim_launcher
    import flop_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [CW-1:0]    NUM_CYCLES,
    output logic [WIDTH-1:0] D_OUT,
    input  logic [WIDTH-1:0] Q_IN,
    input  logic [WIDTH-1:0] QN_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CW-1:0]    TOGGLE_CNT,
    output logic [CW-1:0]    ERR_CNT,
    output logic             ERR_FLAG
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
    localparam logic [SAT_W-1:0]  CNT_MAX  = SAT_W'((64'd1 << CW) - 64'd1);

    state_e            state_q, state_nxt;
    mode_e             mode_q, mode_nxt, launch_mode;
    logic [CW-1:0]     rem_q, rem_nxt;
    logic              chk_vld_q, chk_vld_nxt;
    logic [WIDTH-1:0]  d_nxt, pattern;
    logic [CW-1:0]     tog_nxt, err_nxt;
    logic              flag_nxt, busy_nxt, done_nxt;
    logic              launch, mismatch, lfsr_load, lfsr_adv;
    logic [POP_W-1:0]  pop;
    logic [LFSR_W-1:0] lfsr_q;

    flop_stim_lfsr u_lfsr (
        .CLK   (CLK),
        .RST   (RST),
        .load  (lfsr_load),
        .seed  (SEED_EFF),
        .adv   (lfsr_adv),
        .state (lfsr_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        mode_nxt    = mode_q;
        rem_nxt     = rem_q;
        chk_vld_nxt = 1'b0;
        d_nxt       = D_OUT;
        tog_nxt     = TOGGLE_CNT;
        err_nxt     = ERR_CNT;
        flag_nxt    = ERR_FLAG;
        launch      = 1'b0;
        launch_mode = mode_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        pattern     = '0;
        pop         = '0;

        // D_OUT still holds the previous launch, which is exactly what the flops captured
        mismatch = chk_vld_q && ((Q_IN !== D_OUT) || (QN_IN !== ~D_OUT));
        if (mismatch) begin
            err_nxt  = CW'(sat_add(SAT_W'(ERR_CNT), SAT_W'(1), CNT_MAX));
            flag_nxt = 1'b1;
        end

        case (state_q)
            IDLE, flop_stim_pkg::DONE: begin
                if (START) begin
                    tog_nxt  = '0;
                    err_nxt  = '0;
                    flag_nxt = 1'b0;
                    mode_nxt = mode_e'(MODE);
                    if (NUM_CYCLES == '0) begin
                        state_nxt = flop_stim_pkg::DONE;
                    end else begin
                        launch      = 1'b1;
                        launch_mode = mode_e'(MODE);
                        lfsr_load   = 1'b1;
                        lfsr_adv    = 1'b1;
                        rem_nxt     = NUM_CYCLES - CW'(1);
                        state_nxt   = (NUM_CYCLES == CW'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                launch   = 1'b1;
                lfsr_adv = 1'b1;
                rem_nxt  = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                d_nxt     = '0;
                state_nxt = flop_stim_pkg::DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (launch) begin
            case (launch_mode)
                ALL0:    pattern = '0;
                ALL1:    pattern = '1;
                ALT:     pattern = ~D_OUT;
                LFSR:    pattern = WIDTH'(lfsr_step(lfsr_load ? SEED_EFF : lfsr_q));
                default: pattern = '0;
            endcase
            pop         = popcount16(16'(pattern ^ D_OUT));
            d_nxt       = pattern;
            chk_vld_nxt = 1'b1;
            tog_nxt     = CW'(sat_add(SAT_W'(tog_nxt), SAT_W'(pop), CNT_MAX));
        end

        busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
        done_nxt = (state_nxt == flop_stim_pkg::DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q     <= ALL0;
            rem_q      <= '0;
            chk_vld_q  <= 1'b0;
            D_OUT      <= '0;
            TOGGLE_CNT <= '0;
            ERR_CNT    <= '0;
            ERR_FLAG   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            mode_q     <= mode_nxt;
            rem_q      <= rem_nxt;
            chk_vld_q  <= chk_vld_nxt;
            D_OUT      <= d_nxt;
            TOGGLE_CNT <= tog_nxt;
            ERR_CNT    <= err_nxt;
            ERR_FLAG   <= flag_nxt;
            BUSY       <= busy_nxt;
            DONE       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_flop_stim_launcher.sv
// Directed bench: four negedge flop models on D_OUT/Q/QN with optional lane faults.
module tb_flop_stim_launcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_cycles;
    logic [3:0]  d_out;
    logic [3:0]  q_in;
    logic [3:0]  qn_in;
    logic        busy;
    logic        done;
    logic [15:0] toggle_cnt;
    logic [15:0] err_cnt;
    logic        err_flag;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q_cell = '0;
    logic       lane0_stuck = 1'b0;
    logic       lane1_qn_bad = 1'b0;
    logic       xprobe;
    logic       qn_bad_val;
    logic [3:0] d_hist [0:255];
    int         edges;

    flop_stim_launcher dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .MODE       (mode),
        .NUM_CYCLES (num_cycles),
        .D_OUT      (d_out),
        .Q_IN       (q_in),
        .QN_IN      (qn_in),
        .BUSY       (busy),
        .DONE       (done),
        .TOGGLE_CNT (toggle_cnt),
        .ERR_CNT    (err_cnt),
        .ERR_FLAG   (err_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) q_cell <= d_out;

    // Lane1 QN is X where the simulator has X, otherwise a value that is always wrong
    initial xprobe = 1'bx;
    assign qn_bad_val = ((xprobe !== 1'b0) && (xprobe !== 1'b1)) ? 1'bx : q_cell[1];
    assign q_in  = {q_cell[3:1], lane0_stuck ? 1'b0 : q_cell[0]};
    assign qn_in = {~q_cell[3:2], lane1_qn_bad ? qn_bad_val : ~q_cell[1],
                    lane0_stuck ? 1'b1 : ~q_cell[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch_run(input logic [1:0] m, input logic [15:0] n);
        mode = m;
        num_cycles = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        d_hist[0] = d_out;
        while (!done && edges < 200) begin
            tick();
            d_hist[edges] = d_out;
            edges++;
        end
        check("run_reaches_done", 32'(done), 32'd1);
    endtask

    task automatic check_lfsr_run(input string tag);
        logic [15:0] s;
        logic [3:0]  p;
        logic [3:0]  prev;
        int          tog;
        s = 16'hACE1;
        prev = '0;
        tog = 0;
        for (int i = 0; i < 20; i++) begin
            s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
            p = s[3:0];
            check($sformatf("%s_d%0d", tag, i), 32'(d_hist[i]), 32'(p));
            tog += $countones(p ^ prev);
            prev = p;
        end
        check({tag, "_anchor"}, {16'h0, d_hist[0], d_hist[1], d_hist[2], d_hist[3]}, 32'h08CE);
        check({tag, "_toggle"}, 32'(toggle_cnt), 32'(tog));
        check({tag, "_err"}, 32'(err_cnt), 32'd0);
        check({tag, "_edges"}, 32'(edges), 32'd21);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        num_cycles = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_dout", 32'(d_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_toggle", 32'(toggle_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_flag", 32'(err_flag), 32'd0);

        // ALT, 8 launches: 8 launch edges plus the drain edge
        launch_run(2'd2, 16'd8);
        check("alt_edges", 32'(edges), 32'd9);
        check("alt_seq", {d_hist[0], d_hist[1], d_hist[2], d_hist[3],
                          d_hist[4], d_hist[5], d_hist[6], d_hist[7]}, 32'hF0F0F0F0);
        check("alt_toggle", 32'(toggle_cnt), 32'd32);
        check("alt_err", 32'(err_cnt), 32'd0);
        check("alt_busy_end", 32'(busy), 32'd0);
        check("alt_dout_done", 32'(d_out), 32'd0);
        tick();
        tick();
        check("alt_hold_toggle", 32'(toggle_cnt), 32'd32);
        check("alt_hold_done", 32'(done), 32'd1);

        launch_run(2'd1, 16'd5);
        check("all1_toggle", 32'(toggle_cnt), 32'd4);
        check("all1_err", 32'(err_cnt), 32'd0);
        check("all1_d0", 32'(d_hist[0]), 32'hF);
        launch_run(2'd0, 16'd5);
        check("all0_toggle", 32'(toggle_cnt), 32'd0);
        check("all0_err", 32'(err_cnt), 32'd0);

        lane0_stuck = 1'b1;
        launch_run(2'd2, 16'd8);
        check("stuck0_err", 32'(err_cnt), 32'd4);
        check("stuck0_flag", 32'(err_flag), 32'd1);
        lane0_stuck = 1'b0;
        lane1_qn_bad = 1'b1;
        launch_run(2'd2, 16'd8);
        check("qnx_err", 32'(err_cnt), 32'd8);
        check("qnx_flag", 32'(err_flag), 32'd1);
        lane1_qn_bad = 1'b0;

        launch_run(2'd3, 16'd20);
        check_lfsr_run("lfsr1");
        launch_run(2'd3, 16'd20);
        check_lfsr_run("lfsr2");

        launch_run(2'd2, 16'd0);
        check("n0_edges", 32'(edges), 32'd1);
        check("n0_dout", 32'(d_hist[0]), 32'd0);
        check("n0_toggle", 32'(toggle_cnt), 32'd0);
        check("n0_err", 32'(err_cnt), 32'd0);

        // START, MODE and NUM_CYCLES wiggled mid-run must not disturb the run
        mode = 2'd2;
        num_cycles = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 200) begin
            if (edges == 2 || edges == 5) begin
                start = 1'b1;
                mode = 2'd1;
                num_cycles = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        check("midstart_edges", 32'(edges), 32'd9);
        check("midstart_toggle", 32'(toggle_cnt), 32'd32);

        mode = 2'd2;
        num_cycles = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_dout", 32'(d_out), 32'd0);
        check("midrst_toggle", 32'(toggle_cnt), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        launch_run(2'd2, 16'd2);
        check("after_rst_toggle", 32'(toggle_cnt), 32'd8);
        check("after_rst_edges", 32'(edges), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
